// File: rtl/regfile_wb_queue_if.sv
// Writeback, register-file write port and bypass lookup signals of the writeback queue.
// The master side produces writebacks and lookups; the slave side is the queue itself.
interface regfile_wb_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          wb0_valid;
  logic [AW-1:0] wb0_reg;
  logic [DW-1:0] wb0_data;
  logic          wb1_valid;
  logic [AW-1:0] wb1_reg;
  logic [DW-1:0] wb1_data;
  logic          wb_ready;
  logic          rf_write_enable;
  logic [AW-1:0] rf_write_reg;
  logic [DW-1:0] rf_write_data;
  logic [AW-1:0] byp_reg1;
  logic [AW-1:0] byp_reg2;
  logic          byp_hit1;
  logic [DW-1:0] byp_data1;
  logic          byp_hit2;
  logic [DW-1:0] byp_data2;
  logic          empty;

  modport master (
    output wb0_valid, wb0_reg, wb0_data, wb1_valid, wb1_reg, wb1_data,
    output byp_reg1, byp_reg2,
    input  wb_ready, rf_write_enable, rf_write_reg, rf_write_data,
    input  byp_hit1, byp_data1, byp_hit2, byp_data2, empty
  );

  modport slave (
    input  wb0_valid, wb0_reg, wb0_data, wb1_valid, wb1_reg, wb1_data,
    input  byp_reg1, byp_reg2,
    output wb_ready, rf_write_enable, rf_write_reg, rf_write_data,
    output byp_hit1, byp_data1, byp_hit2, byp_data2, empty
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// Program-ordered writeback queue in front of the 2R/1W register file: accepts two
// results per cycle, drains one per cycle, and exposes pending values for bypass.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic              clk,
  input logic              reset,
  regfile_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] regMem_q  [DEPTH];
  logic [DW-1:0] dataMem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          wbReady, isEmpty, keep0, keep1, deq;
  logic [CW-1:0] keptCount;
  logic          wrEn0, wrEn1;
  logic [AW-1:0] wrReg0, wrReg1;
  logic [DW-1:0] wrData0, wrData1;
  logic [PW-1:0] wrIdx1, idx;
  logic          hit1, hit2;
  logic [DW-1:0] data1, data2;

  // Ready looks only at the registered count, so a same-cycle drain never helps.
  assign wbReady = (count_q <= CW'(DEPTH - 2));
  assign isEmpty = (count_q == '0);
  assign keep0   = wbReady && bus.wb0_valid && (bus.wb0_reg != '0);
  assign keep1   = wbReady && bus.wb1_valid && (bus.wb1_reg != '0);
  assign deq     = !isEmpty;
  assign wrIdx1  = tail_q + PW'(1);

  always_comb begin
    wrEn0     = 1'b0;
    wrEn1     = 1'b0;
    wrReg0    = bus.wb0_reg;
    wrData0   = bus.wb0_data;
    wrReg1    = bus.wb1_reg;
    wrData1   = bus.wb1_data;
    keptCount = '0;
    if (keep0 && keep1) begin
      wrEn0     = 1'b1;
      wrEn1     = 1'b1;
      keptCount = CW'(2);
    end else if (keep0 || keep1) begin
      wrEn0     = 1'b1;
      wrReg0    = keep0 ? bus.wb0_reg  : bus.wb1_reg;
      wrData0   = keep0 ? bus.wb0_data : bus.wb1_data;
      keptCount = CW'(1);
    end
    head_d  = deq ? head_q + PW'(1) : head_q;
    tail_d  = tail_q + PW'(keptCount);
    count_d = count_q + keptCount - {{(CW-1){1'b0}}, deq};
  end

  // Walk oldest to youngest so the last match left standing is the youngest one.
  always_comb begin
    hit1  = 1'b0;
    hit2  = 1'b0;
    data1 = '0;
    data2 = '0;
    idx   = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (bus.byp_reg1 != '0 && regMem_q[idx] == bus.byp_reg1) begin
          hit1  = 1'b1;
          data1 = dataMem_q[idx];
        end
        if (bus.byp_reg2 != '0 && regMem_q[idx] == bus.byp_reg2) begin
          hit2  = 1'b1;
          data2 = dataMem_q[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (wrEn0) begin
        regMem_q[tail_q]  <= wrReg0;
        dataMem_q[tail_q] <= wrData0;
      end
      if (wrEn1) begin
        regMem_q[wrIdx1]  <= wrReg1;
        dataMem_q[wrIdx1] <= wrData1;
      end
    end
  end

  // The head write is suppressed while reset is held so a discarded entry never commits.
  assign bus.rf_write_enable = deq && !reset;
  assign bus.rf_write_reg    = isEmpty ? '0 : regMem_q[head_q];
  assign bus.rf_write_data   = isEmpty ? '0 : dataMem_q[head_q];
  assign bus.wb_ready        = wbReady;
  assign bus.empty           = isEmpty;
  assign bus.byp_hit1        = hit1;
  assign bus.byp_data1       = data1;
  assign bus.byp_hit2        = hit2;
  assign bus.byp_data2       = data2;
endmodule
